// File: rtl/mux_iot_pkg.sv
// mux_iot_pkg: shared types and helpers for the tri-state pad multiplexer.
//   state_t         : handover FSM states (ACTIVE, GUARD)
//   clog2()         : select-width helper, never returns less than 1
//   MUX_IOT_IDLE_IN : value presented on I_O bits that do not own the pad
package mux_iot_pkg;

  typedef enum logic {
    ACTIVE = 1'b0,
    GUARD  = 1'b1
  } state_t;

  localparam logic MUX_IOT_IDLE_IN = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_iot_sync2.sv
// mux_iot_sync2: 1-bit two-flop synchronizer for the pad input path.
//   clk, rst : clock and asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (RST_VAL while in reset)
module mux_iot_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mux_iot_sw.sv
// mux_iot_sw: N-channel tri-state pad multiplexer with guarded handover.
// One bidirectional pad (T_O/O_O/I_I) is shared among CH_NUM users; every
// channel change (and reset release) holds the pad high-Z for GUARD_CYC cycles.
//   CLK_I, RST_I   : clock, asynchronous active-high reset
//   SEL_I, SEL_VLD_I : requested channel and request strobe
//   SEL_BUSY_O     : handover in progress (requests ignored)
//   SEL_ERR_O      : one-cycle pulse for an out-of-range request
//   CUR_SEL_O      : channel currently owning the pad
//   T_I, O_I, I_O  : per-channel tristate enable, output data, input data
//   T_O, O_O, I_I  : pad tristate enable, output data, input data
// Optional macro MUX_IOT_ISYNC_EN: passes I_I through a 2-flop synchronizer.
module mux_iot_sw
  import mux_iot_pkg::*;
#(
  parameter  int unsigned CH_NUM    = 4,
  parameter  int unsigned GUARD_CYC = 4,
  parameter  int unsigned INIT_CH   = 0,
  localparam int unsigned SEL_W     = clog2(CH_NUM)
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [SEL_W-1:0]  SEL_I,
  input  logic              SEL_VLD_I,
  output logic              SEL_BUSY_O,
  output logic              SEL_ERR_O,
  output logic [SEL_W-1:0]  CUR_SEL_O,
  input  logic [CH_NUM-1:0] T_I,
  input  logic [CH_NUM-1:0] O_I,
  output logic [CH_NUM-1:0] I_O,
  output logic              T_O,
  output logic              O_O,
  input  logic              I_I
);

  localparam logic [SEL_W-1:0] INIT_SEL   = SEL_W'(INIT_CH);
  localparam logic [7:0]       GUARD_LAST = (GUARD_CYC == 0) ? 8'd0 : 8'(GUARD_CYC - 1);
  localparam state_t           RST_STATE  = (GUARD_CYC == 0) ? ACTIVE : GUARD;

  state_t           state;
  logic [7:0]       cnt;
  logic [SEL_W-1:0] cur_sel;
  logic [SEL_W-1:0] next_sel;
  logic             sel_bad;
  logic             pad_in;

  assign sel_bad = (32'(SEL_I) >= CH_NUM);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= RST_STATE;
      cnt       <= GUARD_LAST;
      cur_sel   <= INIT_SEL;
      next_sel  <= INIT_SEL;
      SEL_ERR_O <= 1'b0;
    end else begin
      SEL_ERR_O <= 1'b0;
      case (state)
        ACTIVE: begin
          if (SEL_VLD_I) begin
            if (sel_bad) begin
              SEL_ERR_O <= 1'b1;
            end else if (SEL_I != cur_sel) begin
              if (GUARD_CYC == 0) begin
                cur_sel <= SEL_I;
              end else begin
                next_sel <= SEL_I;
                cnt      <= GUARD_LAST;
                state    <= GUARD;
              end
            end
          end
        end
        GUARD: begin
          // Requests are dropped here; only the counter runs.
          if (cnt == 8'd0) begin
            cur_sel <= next_sel;
            state   <= ACTIVE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= GUARD;
      endcase
    end
  end

`ifdef MUX_IOT_ISYNC_EN
  mux_iot_sync2 #(
    .RST_VAL(MUX_IOT_IDLE_IN)
  ) u_isync (
    .clk(CLK_I),
    .rst(RST_I),
    .d  (I_I),
    .q  (pad_in)
  );
`else
  assign pad_in = I_I;
`endif

  // Gating uses the registered state/cur_sel only, so idle I_O bits are
  // forced immediately even when the pad input path is synchronized.
  always_comb begin
    T_O = 1'b1;
    O_O = 1'b0;
    I_O = {CH_NUM{MUX_IOT_IDLE_IN}};
    if (state == ACTIVE) begin
      T_O          = T_I[cur_sel];
      O_O          = O_I[cur_sel];
      I_O[cur_sel] = pad_in;
    end
  end

  assign SEL_BUSY_O = (state == GUARD);
  assign CUR_SEL_O  = cur_sel;

endmodule

// File: doc/mux_iot_sw.md
# mux_iot_sw

Parametrised N-channel tri-state I/O multiplexer. It shares one bidirectional pad (T/O/I triple) among CH_NUM internal users. Channel changes go through a registered handover: the pad is forced to high-Z for a programmable guard interval, so two users never drive it in the same cycle. It sits between the channel controllers and the IOBUF wrapper, replacing the fixed 2-channel combinational mux.

## Interface
- CH_NUM, 4, number of channels (2..16).
- GUARD_CYC, 4, cycles of forced high-Z on every channel change and after reset (0..255).
- INIT_CH, 0, channel that owns the pad after reset (< CH_NUM).
- SEL_W, derived, clog2(CH_NUM); localparam, not overridable.
- CLK_I  in  1  clock
- RST_I  in  1  asynchronous, active-high reset
- SEL_I  in  SEL_W  requested channel
- SEL_VLD_I  in  1  switch request strobe, sampled on CLK_I rising edge
- SEL_BUSY_O  out  1  handover in progress; requests are ignored while high
- SEL_ERR_O  out  1  one-cycle pulse: request rejected (SEL_I >= CH_NUM)
- CUR_SEL_O  out  SEL_W  channel currently owning the pad
- T_I  in  CH_NUM  per-channel tristate enable (1 = high-Z)
- O_I  in  CH_NUM  per-channel output data
- I_O  out  CH_NUM  per-channel input data
- T_O  out  1  pad tristate enable
- O_O  out  1  pad output data
- I_I  in  1  pad input data

## Operation
- States: ACTIVE, GUARD. The registers are state, cur_sel, next_sel, guard counter and SEL_ERR_O.
- ACTIVE:
  - T_O = T_I[cur_sel], O_O = O_I[cur_sel].
  - I_O[cur_sel] = pad input; every other I_O bit is 1.
  - SEL_BUSY_O = 0.
- GUARD:
  - T_O = 1, O_O = 0, all I_O bits = 1.
  - SEL_BUSY_O = 1.
  - The counter decrements each cycle.
  - When the counter is 0, then on that edge: cur_sel <= next_sel and state <= ACTIVE.
- Request handling in ACTIVE with SEL_VLD_I = 1:
  - SEL_I >= CH_NUM: SEL_ERR_O = 1 for the next cycle; no state change.
  - SEL_I == cur_sel: no-op; no GUARD.
  - Otherwise: next_sel <= SEL_I, counter <= GUARD_CYC-1, state <= GUARD.
- GUARD_CYC = 0: cur_sel <= SEL_I directly on the request edge and GUARD is never entered. A reset with GUARD_CYC = 0 also goes straight to ACTIVE.
- SEL_VLD_I in GUARD is ignored: not queued, no error flag.
- Reset mid-handover aborts the handover. next_sel is discarded and the block restarts the reset sequence.

## Timing
- Reset values while RST_I = 1:
  - state = GUARD, counter = GUARD_CYC-1, cur_sel = next_sel = INIT_CH.
  - Resulting outputs: T_O = 1, O_O = 0, I_O = all 1, SEL_BUSY_O = 1, SEL_ERR_O = 0, CUR_SEL_O = INIT_CH.
- After RST_I deasserts, the pad stays high-Z for exactly GUARD_CYC edges, then INIT_CH owns it.
- Request at edge n (valid, different channel):
  - Pad is high-Z from cycle n+1 through n+GUARD_CYC.
  - The new channel drives from cycle n+GUARD_CYC+1.
  - CUR_SEL_O updates at the same edge the new channel takes over.
- T_O, O_O and I_O are combinational from T_I, O_I and I_I, gated by registered state and cur_sel. This adds 0 cycles of data latency when the feature below is compiled out.
- SEL_ERR_O is registered and lasts exactly one cycle per rejected request.

## Configuration
- MUX_IOT_ISYNC_EN defined:
  - I_I passes through a 2-flop synchronizer (reset value 1) before demux.
  - I_O latency is 2 cycles.
  - Non-selected I_O bits and GUARD-state I_O are still forced 1 immediately, not delayed.
- Not defined: I_I feeds the demux combinationally.

## Structure
- Package mux_iot_pkg holds:
  - state enum (ACTIVE, GUARD);
  - clog2 function;
  - constant MUX_IOT_IDLE_IN = 1'b1, the idle value of I_O.
- Sub-module mux_iot_sync2 is the 2-flop synchronizer: 1 bit wide, async active-high reset, reset value as a parameter. It is instantiated only under MUX_IOT_ISYNC_EN.

## Test plan
- Reset release with CH_NUM = 4, GUARD_CYC = 4, INIT_CH = 2:
  - Pad state: T_O = 1 for 4 cycles after deassert; then T_O tracks T_I[2] and O_O tracks O_I[2].
  - Status: CUR_SEL_O = 2, SEL_BUSY_O falls on the 4th edge.
- SEL_I = 3 with a 1-cycle SEL_VLD_I while on channel 2:
  - T_O = 1 and O_O = 0 for cycles n+1..n+4.
  - Channel 3 drives from n+5.
  - I_I toggles appear only on I_O[3]; the other I_O bits stay 1.
- SEL_I = 2 (current channel) -> SEL_BUSY_O stays 0 and outputs are uninterrupted.
- With CH_NUM = 3, SEL_I = 3 -> SEL_ERR_O pulses one cycle; cur_sel is unchanged.
- SEL_VLD_I pulsed with SEL_I = 0 during GUARD toward 1 -> ignored; the handover completes on channel 1.
- RST_I asserted in the 2nd GUARD cycle -> T_O = 1 immediately; after release, channel INIT_CH is restored after GUARD_CYC cycles.
- GUARD_CYC = 0 -> channel switches at the next edge; SEL_BUSY_O never asserts.
